// File: rtl/cordic_req_arbiter_if.sv
// cordic_req_arbiter_if: request and response channels between the requesters and the CORDIC arbiter.
interface cordic_req_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int W       = 16,
    parameter int IDW     = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*W-1:0] req_theta;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [W-1:0]         rsp_sine;
    logic [W-1:0]         rsp_cosine;
    logic                 rsp_err;

    modport master (
        output req_valid, req_theta, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sine, rsp_cosine, rsp_err
    );

    modport slave (
        input  req_valid, req_theta, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sine, rsp_cosine, rsp_err
    );
endinterface

// File: rtl/cordic_req_arbiter.sv
// cordic_req_arbiter: round-robin sharing of one iterative CORDIC engine among NUM_REQ requesters;
// a watchdog turns a hung engine into an error response instead of a locked resource.
module cordic_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int W       = 16,
    parameter int TIMEOUT = 64,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    cordic_req_arbiter_if.slave     bus,
    output logic                    o_eng_start,
    output logic [W-1:0]            o_eng_theta,
    input  logic                    i_eng_done,
    input  logic [W-1:0]            i_eng_sine,
    input  logic [W-1:0]            i_eng_cosine,
    output logic                    o_busy
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;
    localparam int CW = $clog2(TIMEOUT);

    logic [1:0]     r_state;
    logic [IDW-1:0] r_last;
    logic [IDW-1:0] r_id;
    logic [W-1:0]   r_theta;
    logic [W-1:0]   r_sine;
    logic [W-1:0]   r_cosine;
    logic           r_err;
    logic [CW-1:0]  r_wd;
    logic [IDW-1:0] w_gid;
    logic [W-1:0]   w_theta;
    logic           w_hit;
    int             w_dist;

    // Winner is the valid requester at the smallest circular distance after r_last.
    always_comb begin
        w_gid   = '0;
        w_theta = '0;
        w_dist  = NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++)
            if (bus.req_valid[i] && (i + NUM_REQ - 1 - int'(r_last)) % NUM_REQ < w_dist) begin
                w_dist  = (i + NUM_REQ - 1 - int'(r_last)) % NUM_REQ;
                w_gid   = IDW'(i);
                w_theta = bus.req_theta[i*W +: W];
            end
        w_hit = |bus.req_valid;
    end

    always_comb begin
        bus.req_ready  = (r_state == S_IDLE && w_hit) ? NUM_REQ'(1) << w_gid : '0;
        bus.rsp_valid  = r_state == S_RESP;
        bus.rsp_id     = r_id;
        bus.rsp_sine   = r_sine;
        bus.rsp_cosine = r_cosine;
        bus.rsp_err    = r_err;
        o_eng_start    = r_state == S_ISSUE;
        o_eng_theta    = r_theta;
        o_busy         = r_state != S_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_last   <= IDW'(NUM_REQ - 1);
            r_id     <= '0;
            r_theta  <= '0;
            r_sine   <= '0;
            r_cosine <= '0;
            r_err    <= 1'b0;
            r_wd     <= '0;
        end else
            case (r_state)
                S_IDLE:
                    if (w_hit) begin
                        r_state <= S_ISSUE;
                        r_last  <= w_gid;
                        r_id    <= w_gid;
                        r_theta <= w_theta;
                    end
                S_ISSUE: begin
                    r_wd    <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_wd <= r_wd + 1'b1;
                    // A completing engine beats the watchdog on the same edge.
                    if (i_eng_done) begin
                        r_sine   <= i_eng_sine;
                        r_cosine <= i_eng_cosine;
                        r_err    <= 1'b0;
                        r_state  <= S_RESP;
                    end else if (r_wd == CW'(TIMEOUT - 1)) begin
                        r_sine   <= '0;
                        r_cosine <= '0;
                        r_err    <= 1'b1;
                        r_state  <= S_RESP;
                    end
                end
                S_RESP:
                    if (bus.rsp_ready)
                        r_state <= S_IDLE;
                default:
                    r_state <= S_IDLE;
            endcase
endmodule

// File: tb/tb_cordic_req_arbiter.sv
// tb_cordic_req_arbiter: scoreboard bench for the CORDIC request arbiter with a behavioural engine
// that can complete after k cycles, hang, or hold done high.
module tb_cordic_req_arbiter;
    localparam int NUM_REQ = 4;
    localparam int W       = 16;
    localparam int TIMEOUT = 64;
    localparam int IDW     = 2;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [W-1:0]   s;
        logic [W-1:0]   c;
        logic           e;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           eng_start;
    logic [W-1:0]   eng_theta;
    logic           eng_done = 1'b0;
    logic [W-1:0]   eng_sine = '0;
    logic [W-1:0]   eng_cosine = '0;
    logic           busy;

    int n_chk = 0, n_fail = 0;
    int cyc = 0, t_acc = 0, t_start = 0, t_rsp = 0;
    int n_rsp = 0, n_start = 0, n_acc = 0;
    int k_eng = 16, cnt = 0, m_last = NUM_REQ - 1;
    bit hang = 0, stale = 0, p_stall = 0, p_v = 0;
    logic [W-1:0] exp_theta = '0;
    logic [IDW+2*W+1:0] p_rsp = '0;
    exp_t sb[$];
    int grants[$];

    cordic_req_arbiter_if #(.NUM_REQ(NUM_REQ), .W(W), .IDW(IDW)) bus();

    cordic_req_arbiter #(.NUM_REQ(NUM_REQ), .W(W), .TIMEOUT(TIMEOUT), .IDW(IDW)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus),
        .o_eng_start(eng_start),
        .o_eng_theta(eng_theta),
        .i_eng_done(eng_done),
        .i_eng_sine(eng_sine),
        .i_eng_cosine(eng_cosine),
        .o_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] f_sin(input logic [W-1:0] t);
        return t ^ 16'h5A5A;
    endfunction

    function automatic logic [W-1:0] f_cos(input logic [W-1:0] t);
        return t + 16'h1234;
    endfunction

    // Engine model: done rises in the k-th WAIT cycle after the start pulse.
    always @(negedge clk) begin
        if (!reset_n)
            cnt = 0;
        else if (eng_start) begin
            cnt = k_eng + 1;
            eng_sine = f_sin(eng_theta);
            eng_cosine = f_cos(eng_theta);
        end else if (cnt > 0)
            cnt--;
        eng_done = stale || (!hang && cnt == 1);
    end

    // Monitor: grant model, scoreboard push on accept, pop on response handshake.
    always @(negedge clk) begin
        int g;
        exp_t e;
        cyc++;
        if (!reset_n) begin
            check("rst_out", {bus.req_ready, eng_start, eng_theta, bus.rsp_valid, bus.rsp_id,
                              bus.rsp_sine, bus.rsp_cosine, bus.rsp_err, busy}, 64'd0);
            sb.delete();
            m_last = NUM_REQ - 1;
            p_stall = 0;
            p_v = 0;
        end else begin
            if (busy)
                check("ready_busy", bus.req_ready, 64'd0);
            else if (bus.req_valid != 0) begin
                g = -1;
                for (int k = NUM_REQ; k >= 1; k--)
                    if (bus.req_valid[(m_last + k) % NUM_REQ]) g = (m_last + k) % NUM_REQ;
                check("grant", bus.req_ready, 64'(1) << g);
                n_acc++;
                t_acc = cyc;
                m_last = g;
                grants.push_back(g);
                exp_theta = bus.req_theta[g*W +: W];
                e.id = IDW'(g);
                e.s = hang ? '0 : f_sin(exp_theta);
                e.c = hang ? '0 : f_cos(exp_theta);
                e.e = hang;
                sb.push_back(e);
            end
            if (eng_start) begin
                n_start++;
                t_start = cyc;
                check("eng_theta", eng_theta, exp_theta);
            end
            if (p_stall)
                check("stall_hold", {bus.rsp_valid, bus.rsp_id, bus.rsp_sine, bus.rsp_cosine, bus.rsp_err}, p_rsp);
            if (bus.rsp_valid && !p_v)
                t_rsp = cyc;
            if (bus.rsp_valid && bus.rsp_ready) begin
                n_rsp++;
                if (sb.size() == 0)
                    check("sb_empty", sb.size(), 1);
                else begin
                    e = sb.pop_front();
                    check("rsp_id", bus.rsp_id, e.id);
                    check("rsp_sine", bus.rsp_sine, e.s);
                    check("rsp_cosine", bus.rsp_cosine, e.c);
                    check("rsp_err", bus.rsp_err, e.e);
                end
            end
            p_stall = bus.rsp_valid && !bus.rsp_ready;
            p_rsp = {bus.rsp_valid, bus.rsp_id, bus.rsp_sine, bus.rsp_cosine, bus.rsp_err};
            p_v = bus.rsp_valid;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic req(input int id, input logic [W-1:0] th);
        int b;
        b = n_acc;
        bus.req_theta[id*W +: W] = th;
        bus.req_valid = NUM_REQ'(1) << id;
        for (int t = 0; t < 50 && n_acc == b; t++) @(posedge clk);
        #1;
        bus.req_valid = '0;
        check("accept", n_acc, b + 1);
    endtask

    task automatic wait_rsp(input int b, input string tag);
        for (int t = 0; t < 300 && n_rsp == b; t++) @(posedge clk);
        #1;
        check(tag, n_rsp, b + 1);
    endtask

    initial begin
        int b, g0, s0;
        bus.req_valid = '0;
        bus.req_theta = '0;
        bus.rsp_ready = 1'b1;
        tick(3);
        reset_n = 1'b1;
        tick(2);

        // Fairness from a fresh pointer: 0,1,2,3,0,1,2,3
        k_eng = 3;
        bus.req_theta = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        b = n_rsp;
        g0 = grants.size();
        bus.req_valid = 4'hF;
        for (int t = 0; t < 2000 && n_rsp < b + 8; t++) @(posedge clk);
        #1;
        bus.req_valid = '0;
        check("t2_count", n_rsp, b + 8);
        check("t2_ngrant", grants.size(), g0 + 8);
        for (int i = 0; i < 8; i++)
            check($sformatf("t2_order%0d", i), grants[g0 + i], i % 4);
        tick(2);
        check("t2_idle", busy, 0);

        // Single request, engine done after 16 cycles
        k_eng = 16;
        b = n_rsp;
        s0 = n_start;
        req(0, 16'h2000);
        wait_rsp(b, "t1_rsp");
        check("t1_lat", t_rsp - t_acc, 18);
        check("t1_start_lat", t_start - t_acc, 1);
        check("t1_nstart", n_start - s0, 1);

        // Backpressure with other requesters pending
        k_eng = 4;
        bus.rsp_ready = 1'b0;
        b = n_rsp;
        req(1, 16'h1357);
        bus.req_valid = 4'b1101;
        for (int t = 0; t < 100 && !bus.rsp_valid; t++) @(negedge clk);
        check("t3_valid", bus.rsp_valid, 1);
        tick(10);
        check("t3_held", n_rsp, b);
        bus.rsp_ready = 1'b1;
        bus.req_valid = '0;
        tick(4);
        check("t3_one", n_rsp, b + 1);
        check("t3_idle", busy, 0);

        // Watchdog: engine never completes
        hang = 1;
        b = n_rsp;
        req(2, 16'h0F0F);
        wait_rsp(b, "t4_rsp");
        check("t4_wait_cycles", t_rsp - t_start - 1, TIMEOUT);
        hang = 0;
        k_eng = 5;
        b = n_rsp;
        req(3, 16'h7FFF);
        wait_rsp(b, "t4_next");

        // Done on the very last WAIT cycle beats the watchdog
        k_eng = TIMEOUT;
        b = n_rsp;
        req(0, 16'h8000);
        wait_rsp(b, "t4_edge");
        check("t4_edge_lat", t_rsp - t_start - 1, TIMEOUT);

        // Stale done held through ISSUE
        stale = 1;
        k_eng = 10;
        b = n_rsp;
        req(1, 16'h4321);
        wait_rsp(b, "t5_rsp");
        check("t5_lat", t_rsp - t_start, 2);
        stale = 0;
        tick(20);
        check("t5_one", n_rsp, b + 1);

        // Reset during WAIT discards the in-flight result
        k_eng = 40;
        req(2, 16'h1111);
        tick(5);
        check("t6_in_wait", busy, 1);
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        b = n_rsp;
        tick(50);
        check("t6_norsp", n_rsp, b);
        check("t6_idle", busy, 0);
        k_eng = 6;
        g0 = grants.size();
        s0 = n_acc;
        bus.req_valid = 4'hF;
        for (int t = 0; t < 50 && n_acc == s0; t++) @(posedge clk);
        #1;
        bus.req_valid = '0;
        check("t6_accept", n_acc, s0 + 1);
        check("t6_prio", grants[g0], 0);
        wait_rsp(b, "t6_rsp");

        tick(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/cordic_req_arbiter.md
Name: cordic_req_arbiter

Overview:
Shares one iterative CORDIC sine/cosine engine among NUM_REQ requesters. Per requester, a valid/ready request channel carries one angle. The block grants one requester at a time by round-robin, sequences the engine (start pulse, then waits for done), and returns the result with the requester ID on a single valid/ready response channel. A watchdog catches an engine that never completes, so a hung engine cannot lock the shared resource.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
W, 16, angle/result width (signed Q format of the engine)
TIMEOUT, 64, maximum cycles spent in WAIT before the watchdog fires (>= engine iterations + 2)
IDW, $clog2(NUM_REQ), requester ID width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_theta  in  NUM_REQ*W  packed angles; requester i occupies bits [i*W +: W]
req_ready  out  NUM_REQ  one-hot grant/accept
eng_start  out  1  one-cycle start pulse to the engine
eng_theta  out  W  angle presented to the engine, held stable from ISSUE until the result is captured
eng_done  in  1  engine result-valid; may be level or pulse
eng_sine  in  W  engine sine output
eng_cosine  in  W  engine cosine output
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_id  out  IDW  ID of the served requester
rsp_sine  out  W  registered sine
rsp_cosine  out  W  registered cosine
rsp_err  out  1  set when the watchdog fired for this response
busy  out  1  high in every state except IDLE

Behaviour:
Reset (asynchronous, active-low): all of the following go to 0: state, req_ready, eng_start, eng_theta, rsp_valid, rsp_id, rsp_sine, rsp_cosine, rsp_err, busy, watchdog counter. Round-robin pointer last_grant = NUM_REQ-1, so requester 0 has first priority.
The FSM has four states, encoded in 2 bits:
- IDLE
  - Grant g = the first i with req_valid[i]=1, searching from (last_grant+1) mod NUM_REQ upward with wrap.
  - req_ready[g] = 1, combinational, only in IDLE.
  - On the same edge: latch theta_g and ID g, set last_grant = g, go to ISSUE.
  - No req_valid: stay in IDLE, req_ready = 0.
- ISSUE
  - eng_start = 1 for exactly this one cycle; eng_theta = latched theta.
  - Clear the watchdog; go to WAIT.
  - eng_done seen during ISSUE is stale and is ignored.
- WAIT
  - Watchdog increments each cycle.
  - On an edge where eng_done = 1: capture eng_sine/eng_cosine into rsp_sine/rsp_cosine, set rsp_err = 0, go to RESP.
  - If the watchdog reaches TIMEOUT-1 with eng_done = 0: rsp_sine = rsp_cosine = 0, rsp_err = 1, go to RESP.
  - eng_done and timeout on the same edge: eng_done wins.
- RESP
  - rsp_valid = 1; rsp_id/rsp_sine/rsp_cosine/rsp_err held stable until rsp_valid & rsp_ready.
  - On handshake: rsp_valid falls on the next edge, go to IDLE. A new grant can occur the cycle after the handshake.
  - req_ready = 0 for the whole of ISSUE, WAIT and RESP; no queuing of requests.
Latency: request accepted at edge T → eng_start high in cycle T+1 → eng_done sampled at edge T+1+k → rsp_valid high from cycle T+2+k. Minimum throughput is one request per (k+3) cycles.
Fairness: a requester holding req_valid waits at most NUM_REQ-1 other services. A requester that deasserts req_valid before being granted loses nothing; the pointer moves only on a grant.
Reset mid-operation: any state returns to IDLE immediately; an in-flight result is discarded; no response is emitted.
Arithmetic: the block only routes and registers values; no sign or width changes.

Test Plan:
1. Single request: req_valid=0001, theta=16'h2000, engine done after 16 cycles → req_ready=0001 in the same cycle, one eng_start pulse with eng_theta=16'h2000, rsp_valid 18 cycles after accept, rsp_id=0, rsp_err=0, results match the engine model.
2. Fairness: req_valid=1111 held for 8 services → grant order 0,1,2,3,0,1,2,3; rsp_id follows the same sequence.
3. Backpressure: rsp_ready=0 for 10 cycles in RESP → rsp_valid/data/rsp_id stable; req_ready stays 0000; after rsp_ready=1, exactly one handshake and return to IDLE.
4. Watchdog: engine never asserts eng_done, TIMEOUT=64 → RESP entered 64 cycles after ISSUE with rsp_err=1, rsp_sine=rsp_cosine=0; the next request is served normally.
5. Stale done: eng_done held high through ISSUE → ignored in ISSUE, captured at the first WAIT edge; exactly one response.
6. Reset in WAIT: reset_n low for 2 cycles → all outputs 0, no response emitted; after release, requester 0 has priority when req_valid=1111.
